led_pattern_checker: RTL

- Receive-side companion to the LED pattern sequencer.
- Samples the 5-bit LED pattern on a strobe and decodes it to a step index.
- Tracks the 5-step cyclic sequence and declares lock after a run of correct steps.
- Counts completed sequences and reports mismatches, so board and bench logic can check the sequencer output without a waveform viewer.

---
 rtl/led_pattern_checker.sv | 131 +++++++++++++
 1 files changed

// File: rtl/led_pattern_checker.sv
// Receive-side checker for the 5-step LED sequencer: decodes sampled patterns,
// locks onto the cyclic sequence, and counts completed sequences and mismatches.
module led_pattern_checker #(
  parameter int LOCK_COUNT = 4,
  parameter bit ALLOW_HOLD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic [4:0] pattern_in,
  output logic       locked,
  output logic [2:0] cur_index,
  output logic       index_valid,
  output logic       mismatch,
  output logic [7:0] err_count,
  output logic [7:0] seq_count
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [4:0] LOCK_TARGET = 5'(LOCK_COUNT);

  logic [1:0] state, state_nxt;
  logic [2:0] prev, prev_nxt;
  logic [3:0] good_cnt, good_cnt_nxt;
  logic [4:0] good_inc;
  logic [2:0] dec_idx, expected;
  logic       dec_valid, is_good, is_hold, flag_bad, bump_seq;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    dec_idx   = 3'd0;
    dec_valid = 1'b1;
    unique case (pattern_in)
      5'b00000: dec_idx = 3'd0;
      5'b01010: dec_idx = 3'd1;
      5'b00100: dec_idx = 3'd2;
      5'b01110: dec_idx = 3'd3;
      5'b10001: dec_idx = 3'd4;
      default:  dec_valid = 1'b0;
    endcase
  end

  // Successor is taken mod 5 explicitly so the index never visits 5..7.
  assign expected = (prev == 3'd4) ? 3'd0 : prev + 3'd1;
  assign is_good  = dec_valid && (dec_idx == expected);
  assign is_hold  = dec_valid && (dec_idx == prev) && ALLOW_HOLD;
  assign good_inc = {1'b0, good_cnt} + 5'd1;

  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    good_cnt_nxt = good_cnt;
    flag_bad     = 1'b0;
    bump_seq     = 1'b0;
    case (state)
      ST_HUNT: begin
        if (dec_valid) begin
          state_nxt    = ST_TRACK;
          prev_nxt     = dec_idx;
          good_cnt_nxt = 4'd0;
        end
      end
      ST_TRACK: begin
        if (is_good) begin
          prev_nxt = dec_idx;
          if (good_inc == LOCK_TARGET) begin
            state_nxt    = ST_LOCKED;
            good_cnt_nxt = 4'd0;
          end else begin
            good_cnt_nxt = good_inc[3:0];
          end
        end else if (!is_hold) begin
          if (dec_valid) begin
            prev_nxt     = dec_idx;
            good_cnt_nxt = 4'd0;
          end else begin
            state_nxt = ST_HUNT;
          end
        end
      end
      ST_LOCKED: begin
        if (is_good) begin
          prev_nxt = dec_idx;
          bump_seq = (prev == 3'd4) && (dec_idx == 3'd0);
        end else if (!is_hold) begin
          flag_bad     = 1'b1;
          good_cnt_nxt = 4'd0;
          if (dec_valid) begin
            state_nxt = ST_TRACK;
            prev_nxt  = dec_idx;
          end else begin
            state_nxt = ST_HUNT;
          end
        end
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state       <= ST_HUNT;
      prev        <= 3'd0;
      good_cnt    <= 4'd0;
      locked      <= 1'b0;
      cur_index   <= 3'd0;
      index_valid <= 1'b0;
      mismatch    <= 1'b0;
      err_count   <= 8'd0;
      seq_count   <= 8'd0;
    end else begin
      mismatch <= 1'b0;
      if (sample_tick) begin
        state       <= state_nxt;
        prev        <= prev_nxt;
        good_cnt    <= good_cnt_nxt;
        locked      <= (state_nxt == ST_LOCKED);
        cur_index   <= dec_idx;
        index_valid <= dec_valid;
        mismatch    <= flag_bad;
        if (flag_bad && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        if (bump_seq) seq_count <= seq_count + 8'd1;
      end
    end
  end

endmodule
